// File: rtl/ahb_pkg.sv
// Shared AHB types, transfer-size codes and data alignment helpers.
`include "const_defines.svh"

package ahb_pkg;

    localparam int unsigned AHB_ADDR_W = `AHB_ADDR_WIDTH;
    localparam int unsigned AHB_DATA_W = `AHB_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    // RV32 funct3 size codes
    localparam logic [2:0] RW_B  = 3'b000;
    localparam logic [2:0] RW_H  = 3'b001;
    localparam logic [2:0] RW_W  = 3'b010;
    localparam logic [2:0] RW_BU = 3'b100;
    localparam logic [2:0] RW_HU = 3'b101;

    // Replicate right-justified store data across all byte lanes
    function automatic logic [31:0] store_replicate(input logic [2:0]  rwtyp,
                                                    input logic [31:0] wdata);
        logic [31:0] res;
        case (rwtyp)
            RW_B, RW_BU: res = {4{wdata[7:0]}};
            RW_H, RW_HU: res = {2{wdata[15:0]}};
            default:     res = wdata;
        endcase
        return res;
    endfunction

    // Pick the addressed lane out of a bus word and sign/zero extend it
    function automatic logic [31:0] load_extend(input logic [2:0]  rwtyp,
                                                input logic [1:0]  addr_lo,
                                                input logic [31:0] rdata);
        logic [7:0]  lane;
        logic [15:0] half;
        logic [31:0] res;
        case (addr_lo)
            2'd0:    lane = rdata[7:0];
            2'd1:    lane = rdata[15:8];
            2'd2:    lane = rdata[23:16];
            default: lane = rdata[31:24];
        endcase
        half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (rwtyp)
            RW_B:    res = {{24{lane[7]}}, lane};
            RW_BU:   res = {24'd0, lane};
            RW_H:    res = {{16{half[15]}}, half};
            RW_HU:   res = {16'd0, half};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // Misaligned halfword/word or an unsupported size code
    function automatic logic is_bad_req(input logic [2:0] rwtyp,
                                        input logic [1:0] addr_lo);
        logic bad;
        case (rwtyp)
            RW_B, RW_BU: bad = 1'b0;
            RW_H, RW_HU: bad = addr_lo[0];
            RW_W:        bad = (addr_lo != 2'd0);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/const_defines.svh
// Global AHB bus widths shared by the initiator and slave-side logic.
`ifndef CONST_DEFINES_SVH
`define CONST_DEFINES_SVH

`define AHB_ADDR_WIDTH 32
`define AHB_DATA_WIDTH 32

`endif

// File: rtl/lsu_data_align.sv
// Combinational store-lane replication and load lane-select/extension.
module lsu_data_align
    import ahb_pkg::*;
(
    input  logic [2:0]  rwtyp,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    // Bus-facing store data and core-facing load data
    assign wdata_rep = store_replicate(rwtyp, wdata);
    assign rdata_ext = load_extend(rwtyp, addr_lo, rdata);

endmodule

// File: rtl/ahb_master_lsu.sv
// Single-outstanding load/store unit driving non-pipelined AHB transfers.
module ahb_master_lsu
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_W  = AHB_ADDR_W,
    parameter int unsigned DATA_W  = AHB_DATA_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [2:0]        req_rwtyp,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic              hsel,
    output logic [2:0]        hrwtyp,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    lsu_state_t        state;
    lsu_state_t        state_nxt;

    logic [1:0]        addr_lo_q;
    logic              we_q;
    logic [2:0]        rwtyp_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;

    logic              bad_req;
    logic              timeout_hit;
    logic              accept;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] rdata_ext;

    logic              hsel_nxt;
    logic              hwrite_nxt;
    logic [2:0]        hrwtyp_nxt;
    logic [ADDR_W-1:0] haddr_nxt;
    logic [DATA_W-1:0] hwdata_nxt;
    logic              rsp_valid_nxt;
    logic              rsp_err_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;

    assign req_ready   = (state == ST_IDLE) && !rst;
    assign accept      = (state == ST_IDLE) && req_valid;
    assign bad_req     = is_bad_req(req_rwtyp, req_addr[1:0]);
    // Terminal count reached on the TIMEOUT-th data-phase cycle
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    lsu_data_align u_align (
        .rwtyp     (rwtyp_q),
        .addr_lo   (addr_lo_q),
        .wdata     (wdata_q),
        .rdata     (hrdata),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; hready beats the timeout when both occur
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = bad_req ? ST_RESP : ST_ADDR;
                end
            end
            ST_ADDR: state_nxt = ST_DATA;
            ST_DATA: begin
                if (hready || timeout_hit) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered bus and response outputs
    always_comb begin
        hsel_nxt      = 1'b0;
        hwrite_nxt    = 1'b0;
        hrwtyp_nxt    = 3'd0;
        haddr_nxt     = haddr;
        hwdata_nxt    = hwdata;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (bad_req) begin
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                        rsp_rdata_nxt = '0;
                    end else begin
                        hsel_nxt   = 1'b1;
                        haddr_nxt  = req_addr;
                        hwrite_nxt = req_we;
                        hrwtyp_nxt = req_rwtyp;
                    end
                end
            end
            ST_ADDR: begin
                hsel_nxt   = 1'b1;
                hwrite_nxt = we_q;
                hrwtyp_nxt = rwtyp_q;
                hwdata_nxt = wdata_rep;
            end
            ST_DATA: begin
                if (hready) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = hresp;
                    rsp_rdata_nxt = (hresp || we_q) ? '0 : rdata_ext;
                end else if (timeout_hit) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                end else begin
                    hsel_nxt   = 1'b1;
                    hwrite_nxt = we_q;
                    hrwtyp_nxt = rwtyp_q;
                end
            end
            default: ;
        endcase
    end

    // Output, request-capture and timeout-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hsel      <= 1'b0;
            hwrite    <= 1'b0;
            hrwtyp    <= 3'd0;
            haddr     <= '0;
            hwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            addr_lo_q <= 2'd0;
            we_q      <= 1'b0;
            rwtyp_q   <= 3'd0;
            wdata_q   <= '0;
            cnt       <= '0;
        end else begin
            hsel      <= hsel_nxt;
            hwrite    <= hwrite_nxt;
            hrwtyp    <= hrwtyp_nxt;
            haddr     <= haddr_nxt;
            hwdata    <= hwdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            if (accept) begin
                addr_lo_q <= req_addr[1:0];
                we_q      <= req_we;
                rwtyp_q   <= req_rwtyp;
                wdata_q   <= req_wdata;
            end
            if (state_nxt == ST_ADDR) begin
                cnt <= '0;
            end else if (state == ST_DATA && cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ahb_master_lsu.sv
// Randomised and directed bench for ahb_master_lsu against a transfer-level model.
module tb_ahb_master_lsu;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [2:0]  req_rwtyp = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] haddr;
    logic        hwrite;
    logic        hsel;
    logic [2:0]  hrwtyp;
    logic [31:0] hwdata;
    logic        hready = 1'b0;
    logic        hresp = 1'b0;
    logic [31:0] hrdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          hsel_cnt;
        logic [31:0] haddr;
        logic        hwrite;
        logic [2:0]  hrwtyp;
        logic [31:0] hwdata;
        logic        stable;
        logic        rdy_rsp;
        logic        pulse_end;
    } obs_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          hsel_cnt;
        logic [31:0] hwdata;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [2:0]  rwtyp;
        logic [31:0] wdata;
        int          waits;
        logic        resp;
        logic [31:0] rdata;
    } vec_t;

    always #5 clk = ~clk;

    ahb_master_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_rwtyp (req_rwtyp),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsel      (hsel),
        .hrwtyp    (hrwtyp),
        .hwdata    (hwdata),
        .hready    (hready),
        .hresp     (hresp),
        .hrdata    (hrdata)
    );

    // Transfer-level reference: what the core and the bus should see for one request
    function automatic exp_t model(input logic [31:0] addr, input logic we, input logic [2:0] rwtyp,
                                   input logic [31:0] wdata, input int waits, input logic resp,
                                   input logic [31:0] rdata);
        exp_t        e;
        int          size;
        logic        bad;
        logic        tout;
        int          dcyc;
        logic [31:0] v;
        case (rwtyp)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        bad  = (size == 0) || ((addr % size) != 0);
        tout = !bad && (TMO != 0) && (waits >= TMO);
        dcyc = tout ? TMO : waits + 1;
        e.lat      = bad ? 1 : 2 + dcyc;
        e.hsel_cnt = bad ? 0 : 1 + dcyc;
        e.err      = bad || tout || resp;
        if (size == 1)      e.hwdata = (wdata % 256) * 32'h0101_0101;
        else if (size == 2) e.hwdata = (wdata % 65536) * 32'h0001_0001;
        else                e.hwdata = wdata;
        if (size == 1) begin
            v = (rdata >> (8 * (addr % 4))) % 256;
            if (rwtyp == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 2) begin
            v = (rdata >> (16 * ((addr / 2) % 2))) % 65536;
            if (rwtyp == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        e.rdata = (e.err || we) ? 32'd0 : v;
        return e;
    endfunction

    // Core driver plus slave responder for one request; records what was observed
    task automatic do_xfer(input logic [31:0] addr, input logic we, input logic [2:0] rwtyp,
                           input logic [31:0] wdata, input int waits, input logic resp,
                           input logic [31:0] rdata, output obs_t o);
        int guard;
        o.lat = -1; o.rdata = '0; o.err = 1'b0; o.hsel_cnt = 0; o.haddr = '0; o.hwrite = 1'b0;
        o.hrwtyp = '0; o.hwdata = '0; o.stable = 1'b1; o.rdy_rsp = 1'b1; o.pulse_end = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_addr = addr; req_we = we; req_rwtyp = rwtyp; req_wdata = wdata;
        hready = 1'($urandom); hresp = 1'($urandom); hrdata = $urandom;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0; req_addr = $urandom; req_we = 1'($urandom);
                req_rwtyp = 3'($urandom); req_wdata = $urandom;
            end
            if (hsel) begin
                o.hsel_cnt++;
                if (o.hsel_cnt == 1) begin
                    o.haddr = haddr; o.hwrite = hwrite; o.hrwtyp = hrwtyp;
                end else if (haddr !== o.haddr || hwrite !== o.hwrite || hrwtyp !== o.hrwtyp) begin
                    o.stable = 1'b0;
                end
                if (o.hsel_cnt == 2) o.hwdata = hwdata;
                else if (o.hsel_cnt > 2 && hwdata !== o.hwdata) o.stable = 1'b0;
            end
            if (rsp_valid) begin
                o.lat = c; o.rdata = rsp_rdata; o.err = rsp_err; o.rdy_rsp = req_ready;
                hready = 1'b0;
                @(negedge clk);
                o.pulse_end = (rsp_valid === 1'b0) && (req_ready === 1'b1);
                break;
            end
            if (c >= 2) begin
                hready = (c - 2 >= waits);
                hresp  = hready ? resp : 1'($urandom);
                hrdata = rdata;
            end else begin
                hready = 1'($urandom); hresp = 1'($urandom); hrdata = $urandom;
            end
        end
        hready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
        n_cmp++; if (hsel !== 1'b0) begin n_bad++; $display("FAIL reset_hsel got %b exp 0", hsel); end
        n_cmp++; if (hwrite !== 1'b0) begin n_bad++; $display("FAIL reset_hwrite got %b exp 0", hwrite); end
        n_cmp++; if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
        n_cmp++; if (haddr !== 32'd0) begin n_bad++; $display("FAIL reset_haddr got %h exp 0", haddr); end
        n_cmp++; if (hwdata !== 32'd0) begin n_bad++; $display("FAIL reset_hwdata got %h exp 0", hwdata); end
        n_cmp++; if (hrwtyp !== 3'd0) begin n_bad++; $display("FAIL reset_hrwtyp got %h exp 0", hrwtyp); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_first_idle_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_directed();
        vec_t v[12];
        obs_t o;
        exp_t e;
        v[0]  = '{32'h0000_0010, 1'b1, 3'd2, 32'hDEAD_BEEF, 0, 1'b0, 32'h0};
        v[1]  = '{32'h0000_0013, 1'b0, 3'd0, 32'h0, 0, 1'b0, 32'h80FF_0000};
        v[2]  = '{32'h0000_0013, 1'b0, 3'd4, 32'h0, 0, 1'b0, 32'h80FF_0000};
        v[3]  = '{32'h0000_0012, 1'b0, 3'd1, 32'h0, 2, 1'b0, 32'h8001_1234};
        v[4]  = '{32'h0000_0002, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h1111_1111};
        v[5]  = '{32'h0000_0040, 1'b0, 3'd2, 32'h0, 1, 1'b1, 32'hCAFE_F00D};
        v[6]  = '{32'h0000_0044, 1'b0, 3'd2, 32'h0, 10, 1'b0, 32'h5555_AAAA};
        v[7]  = '{32'h0000_0048, 1'b0, 3'd2, 32'h0, 3, 1'b0, 32'h1234_5678};
        v[8]  = '{32'h0000_0021, 1'b1, 3'd0, 32'h0000_00A5, 0, 1'b0, 32'h0};
        v[9]  = '{32'h0000_0022, 1'b1, 3'd1, 32'hFFFF_1234, 1, 1'b0, 32'h0};
        v[10] = '{32'h0000_0000, 1'b0, 3'd3, 32'h0, 0, 1'b0, 32'hFFFF_FFFF};
        v[11] = '{32'h0000_0016, 1'b0, 3'd5, 32'h0, 0, 1'b0, 32'h8001_F00D};
        for (int i = 0; i < 12; i++) begin
            e = model(v[i].addr, v[i].we, v[i].rwtyp, v[i].wdata, v[i].waits, v[i].resp, v[i].rdata);
            do_xfer(v[i].addr, v[i].we, v[i].rwtyp, v[i].wdata, v[i].waits, v[i].resp, v[i].rdata, o);
            n_cmp++; if (o.lat !== e.lat) begin n_bad++; $display("FAIL dir[%0d] latency got %0d exp %0d", i, o.lat, e.lat); end
            n_cmp++; if (o.rdata !== e.rdata) begin n_bad++; $display("FAIL dir[%0d] rdata got %h exp %h", i, o.rdata, e.rdata); end
            n_cmp++; if (o.err !== e.err) begin n_bad++; $display("FAIL dir[%0d] err got %b exp %b", i, o.err, e.err); end
            n_cmp++; if (o.hsel_cnt !== e.hsel_cnt) begin n_bad++; $display("FAIL dir[%0d] hsel_cycles got %0d exp %0d", i, o.hsel_cnt, e.hsel_cnt); end
            n_cmp++; if (o.rdy_rsp !== 1'b0 || o.pulse_end !== 1'b1) begin n_bad++; $display("FAIL dir[%0d] rsp_pulse ready_in_resp=%b clean_end=%b exp 0/1", i, o.rdy_rsp, o.pulse_end); end
            if (e.hsel_cnt > 0) begin
                n_cmp++; if (o.haddr !== v[i].addr) begin n_bad++; $display("FAIL dir[%0d] haddr got %h exp %h", i, o.haddr, v[i].addr); end
                n_cmp++; if (o.hwrite !== v[i].we || o.hrwtyp !== v[i].rwtyp) begin n_bad++; $display("FAIL dir[%0d] ctrl got w=%b t=%h exp w=%b t=%h", i, o.hwrite, o.hrwtyp, v[i].we, v[i].rwtyp); end
                n_cmp++; if (o.hwdata !== e.hwdata) begin n_bad++; $display("FAIL dir[%0d] hwdata got %h exp %h", i, o.hwdata, e.hwdata); end
                n_cmp++; if (o.stable !== 1'b1) begin n_bad++; $display("FAIL dir[%0d] ctrl_stable got %b exp 1", i, o.stable); end
            end
        end
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        logic [31:0] addr, wdata, rdata;
        logic        we, resp;
        logic [2:0]  rwtyp;
        int          waits;
        logic [2:0]  legal[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 40; i++) begin
            addr  = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            we    = 1'($urandom);
            rwtyp = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal[$urandom_range(0, 4)];
            wdata = $urandom;
            rdata = $urandom;
            waits = int'($urandom_range(0, 6));
            resp  = ($urandom_range(0, 4) == 0);
            e = model(addr, we, rwtyp, wdata, waits, resp, rdata);
            do_xfer(addr, we, rwtyp, wdata, waits, resp, rdata, o);
            n_cmp++; if (o.lat !== e.lat) begin n_bad++; $display("FAIL rnd[%0d] latency got %0d exp %0d", i, o.lat, e.lat); end
            n_cmp++; if (o.rdata !== e.rdata || o.err !== e.err) begin n_bad++; $display("FAIL rnd[%0d] rsp got %h/%b exp %h/%b", i, o.rdata, o.err, e.rdata, e.err); end
            n_cmp++; if (o.hsel_cnt !== e.hsel_cnt) begin n_bad++; $display("FAIL rnd[%0d] hsel_cycles got %0d exp %0d", i, o.hsel_cnt, e.hsel_cnt); end
            if (e.hsel_cnt > 0) begin
                n_cmp++; if (o.haddr !== addr || o.hwrite !== we || o.hrwtyp !== rwtyp) begin n_bad++; $display("FAIL rnd[%0d] ctrl got %h/%b/%h exp %h/%b/%h", i, o.haddr, o.hwrite, o.hrwtyp, addr, we, rwtyp); end
                n_cmp++; if (o.hwdata !== e.hwdata || o.stable !== 1'b1) begin n_bad++; $display("FAIL rnd[%0d] hwdata got %h stable=%b exp %h", i, o.hwdata, o.stable, e.hwdata); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int   p[$];
        int   p0, p1;
        logic rdy3, rdy4;
        int   guard = 0;
        rdy3 = 1'bx; rdy4 = 1'bx;
        @(negedge clk);
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        req_valid = 1'b1; req_we = 1'b1; req_rwtyp = 3'd2; req_addr = 32'h0000_0200; req_wdata = $urandom;
        hready = 1'b1; hresp = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (rsp_valid) p.push_back(c);
            if (c == 3) rdy3 = req_ready;
            if (c == 4) rdy4 = req_ready;
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        hready = 1'b0;
        p0 = (p.size() > 0) ? p[0] : -1;
        p1 = (p.size() > 1) ? p[1] : -1;
        n_cmp++; if (p.size() !== 2) begin n_bad++; $display("FAIL b2b_pulse_count got %0d exp 2", p.size()); end
        n_cmp++; if (p0 !== 3 || p1 !== 7) begin n_bad++; $display("FAIL b2b_pulse_cycles got %0d,%0d exp 3,7", p0, p1); end
        n_cmp++; if (rdy3 !== 1'b0 || rdy4 !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got resp=%b idle=%b exp 0/1", rdy3, rdy4); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        exp_t e;
        int   guard = 0;
        int   seen = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        req_valid = 1'b1; req_we = 1'b0; req_rwtyp = 3'd2; req_addr = 32'h0000_0100;
        hready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (hsel !== 1'b1) begin n_bad++; $display("FAIL rstmid_hsel_before got %b exp 1", hsel); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (hsel !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_abort got hsel=%b rsp_valid=%b exp 0/0", hsel, rsp_valid); end
        rst = 1'b0;
        hready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid || hsel) seen++;
        end
        hready = 1'b0;
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_no_activity got %0d active cycles exp 0", seen); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle got req_ready=%b exp 1", req_ready); end
        e = model(32'h0000_0010, 1'b1, 3'd2, 32'h0BAD_CAFE, 0, 1'b0, 32'h0);
        do_xfer(32'h0000_0010, 1'b1, 3'd2, 32'h0BAD_CAFE, 0, 1'b0, 32'h0, o);
        n_cmp++; if (o.lat !== e.lat || o.err !== e.err) begin n_bad++; $display("FAIL rstmid_follow_sw got lat=%0d err=%b exp lat=%0d err=%b", o.lat, o.err, e.lat, e.err); end
        n_cmp++; if (o.hwdata !== e.hwdata || o.hsel_cnt !== e.hsel_cnt) begin n_bad++; $display("FAIL rstmid_follow_bus got %h/%0d exp %h/%0d", o.hwdata, o.hsel_cnt, e.hwdata, e.hsel_cnt); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ahb_master_lsu.md
# ahb_master_lsu

Core-side AHB initiator that converts single load/store requests from the RV32 pipeline into non-pipelined AHB transfers toward the RAM and peripheral slaves on the same bus. It aligns store data, sign- or zero-extends load data, and detects misaligned accesses locally. It also bounds every transfer with a timeout so a dead slave cannot hang the core. One transfer is outstanding at a time.

## Interface
- `ADDR_W`, default 32: AHB / request address width.
- `DATA_W`, default 32: data width; only 32 is supported.
- `TIMEOUT`, default 255: maximum data-phase cycles before an abort; 0 disables the timeout.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: block can accept a request.
- `req_addr` in ADDR_W: byte address.
- `req_we` in 1: 1 = store, 0 = load.
- `req_rwtyp` in 3: RV32 funct3 size code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: response pulse, one cycle.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: response is an error (misaligned, hresp, or timeout).
- `haddr` out ADDR_W, `hwrite` out 1, `hsel` out 1, `hrwtyp` out 3, `hwdata` out 32: AHB control and write data.
- `hready` in 1, `hresp` in 1, `hrdata` in 32: slave handshake, error flag, and read data.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, capture addr, we, rwtyp, and wdata.
  - Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]≠0. A misaligned request goes to RESP with err=1 and no bus activity. An illegal rwtyp (011/110/111) is handled the same way.
  - Otherwise go to ADDR.
- ADDR, exactly one cycle:
  - `hsel`=1; `haddr`, `hwrite`, and `hrwtyp` are driven from the captured request.
  - Go to DATA.
- DATA:
  - `hsel` stays 1 and the control signals are held stable.
  - `hwdata` is the store data replicated across lanes: B gives {4{b}}, H gives {2{h}}, W is passed through.
  - The timeout counter increments each cycle.
  - When `hready`=1:
    - Latch the error as `hresp`.
    - For loads, select the lane by addr[1:0] and extend according to rwtyp.
    - Go to RESP.
  - If the counter reaches `TIMEOUT` before `hready`, go to RESP with err=1 and drop `hsel`.
- RESP, one cycle:
  - `rsp_valid`=1, with data and err registered.
  - Return to IDLE.
  - `req_ready` is 0 in this state, so there is no back-to-back accept.
- `hsel`, `hwrite`, and `hrwtyp` are 0 in IDLE and RESP. `haddr` and `hwdata` hold their last value (don't-care).
- Reset mid-transfer: the FSM goes to IDLE next cycle and `hsel` drops. No response is produced for the aborted request.

## Timing
- Reset values: `req_ready`=0 during reset and 1 in the first IDLE cycle after it. `rsp_valid`, `rsp_err`, `hsel`, and `hwrite` are 0. `rsp_rdata`, `haddr`, `hwdata`, and `hrwtyp` are 0.
- Minimum latency from request accept to `rsp_valid` is 3 cycles (accept → ADDR → DATA with `hready`=1 → RESP). Each wait state on `hready` adds 1 cycle.
- A misaligned request responds 1 cycle after accept.
- Throughput is at most one transfer per 4 cycles.
- A request with `req_valid`=1 while `req_ready`=0 is not accepted; the core must hold it.
- `hready` is ignored outside DATA.
- Timeout counter: 8 bits minimum, sized $clog2(TIMEOUT+1), cleared on entry to ADDR. It saturates and never wraps.
- If `hready` and the timeout terminal count occur in the same cycle, `hready` wins: normal completion.
- Extension rules:
  - B: sign bit is lane[7]. H: sign bit is half[15].
  - BU and HU zero-fill.
  - W ignores addr[1:0].

## Structure
- Shared package `ahb_pkg`:
  - FSM state enum.
  - rwtyp localparams (RW_B, RW_H, RW_W, RW_BU, RW_HU).
  - Store-replication and load-extension functions, which are reusable by `ahb2ram`-side logic.
- One sub-module, `lsu_data_align`: purely combinational store replication and load lane-select/extension, instantiated once.
- Widths come from `const_defines.svh` (`AHB_ADDR_WIDTH`, `AHB_DATA_WIDTH`).

## Test plan
- Store word: SW 0x0000_0010 ← 0xDEADBEEF with `hready` tied high → `hsel` high in cycles 1–2 with `hwrite`=1, `hwdata`=0xDEADBEEF; `rsp_valid` in cycle 3 with err=0.
- Load byte signed: LB at 0x13 with `hrdata`=0x80FF_0000 → `rsp_rdata`=0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- Load halfword with 2 wait states: LH at 0x12 with `hrdata`=0x8001_1234 and `hready` low for 2 cycles → `rsp_rdata`=0xFFFF_8001, latency 5.
- Misaligned: LW at 0x02 → no `hsel` pulse; `rsp_valid`=1 and `rsp_err`=1 one cycle after accept.
- Errors:
  - `hresp`=1 on completion → `rsp_err`=1.
  - `hready` held 0 with `TIMEOUT`=4 → abort, `rsp_err`=1 after 4 DATA cycles.
  - `hready` rising on the 4th cycle → normal completion.
- Reset mid-DATA: assert `rst` during a wait state → next cycle `hsel`=0 and the FSM is in IDLE with no `rsp_valid`. A following SW completes normally.
